// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling rate and the
// default frame geometry used by the transmitter, receiver and tick generator.
package uart_pkg;

   // Oversampling ticks per bit period.
   localparam int OVS = 16;

   // Default frame geometry shared across the UART datapath.
   localparam int DBIT_DEF    = 8;
   localparam int SB_TICK_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART serial transmitter. Accepts one DBIT-wide word per start strobe while
// idle and shifts it out LSB first framed by a start bit and a stop period,
// pacing every bit with the shared 16x oversampling tick.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_s_tick,
   input  logic            i_tx_start,
   input  logic [DBIT-1:0] i_din,
   output logic            o_tx,
   output logic            o_tx_done_tick,
   output logic            o_busy
);

   // Tick counter must reach both OVS-1 and SB_TICK-1 (up to 31 for 2 stop bits).
   localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int N_W = $clog2(DBIT);

   localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVS - 1);
   localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

   uart_state_t     state_reg, state_next;
   logic [S_W-1:0]  s_reg, s_next;
   logic [N_W-1:0]  n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            tx_reg, tx_next;
   logic            done_tick;

   // State, counters, shift register and line register; reset drops any frame in flight.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         tx_reg    <= tx_next;
      end
   end

   // Next-state logic: everything past IDLE advances only on oversampling ticks.
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      unique case (state_reg)
         IDLE: begin
            // A tick coincident with the start is not counted; s starts from 0.
            if (i_tx_start) begin
               b_next     = i_din;
               s_next     = '0;
               state_next = START;
            end
         end
         START: begin
            if (i_s_tick) begin
               if (s_reg == S_BIT_LAST) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = DATA;
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         DATA: begin
            if (i_s_tick) begin
               if (s_reg == S_BIT_LAST) begin
                  s_next = '0;
                  b_next = b_reg >> 1;
                  if (n_reg == N_LAST) begin
                     state_next = STOP;
                  end else begin
                     n_next = n_reg + N_W'(1);
                  end
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         STOP: begin
            if (i_s_tick) begin
               if (s_reg == S_STOP_LAST) begin
                  state_next = IDLE;
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output logic: line level for the next cycle and the end-of-stop done pulse.
   always_comb begin
      tx_next   = 1'b1;
      done_tick = 1'b0;
      unique case (state_reg)
         IDLE:  tx_next = 1'b1;
         START: tx_next = 1'b0;
         DATA:  tx_next = b_reg[0];
         STOP: begin
            tx_next   = 1'b1;
            done_tick = i_s_tick && (s_reg == S_STOP_LAST);
         end
         default: tx_next = 1'b1;
      endcase
   end

   assign o_tx           = tx_reg;
   assign o_tx_done_tick = done_tick;
   assign o_busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a line monitor decodes frames by mid-bit sampling
// against the oversampling tick and feeds a queue that each scenario task
// compares with the words it queued when it drove the start strobe.
module tb_uart_tx;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;

   typedef struct {
      logic [DBIT-1:0] data;
      bit              start_ok;
      bit              stop_ok;
      int              fall_cyc;
   } frame_t;

   logic            i_clk;
   logic            i_reset;
   logic            i_s_tick;
   logic            i_tx_start;
   logic [DBIT-1:0] i_din;
   logic            o_tx;
   logic            o_tx_done_tick;
   logic            o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DBIT-1:0] exp_q[$];
   frame_t          got_q[$];

   int tick_div = 1;
   bit tick_en  = 1'b1;
   int tick_cnt = 0;

   int     cyc      = 0;
   int     done_cnt = 0;
   bit     mon_on   = 1'b0;
   int     mon_t    = 0;
   frame_t mon_f;

   uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_s_tick       (i_s_tick),
      .i_tx_start     (i_tx_start),
      .i_din          (i_din),
      .o_tx           (o_tx),
      .o_tx_done_tick (o_tx_done_tick),
      .o_busy         (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Tick source: every cycle when tick_div <= 1, else one pulse every tick_div cycles.
   initial begin
      i_s_tick = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         if (tick_div <= 1) begin
            i_s_tick = tick_en;
         end else begin
            tick_cnt++;
            if (tick_cnt >= tick_div) begin
               tick_cnt = 0;
               i_s_tick = tick_en;
            end else begin
               i_s_tick = 1'b0;
            end
         end
      end
   end

   // Line monitor: detect the falling start edge, then sample at tick 8 + 16*k.
   always @(negedge i_clk) begin
      cyc++;
      if (i_reset) begin
         mon_on = 1'b0;
      end else begin
         if (!mon_on && o_tx === 1'b0) begin
            mon_on         = 1'b1;
            mon_t          = 0;
            mon_f.data     = '0;
            mon_f.start_ok = 1'b0;
            mon_f.stop_ok  = 1'b0;
            mon_f.fall_cyc = cyc;
         end
         if (mon_on && i_s_tick === 1'b1) begin
            mon_t++;
            if (mon_t == 8) begin
               mon_f.start_ok = (o_tx === 1'b0);
            end else if (mon_t >= 24 && mon_t < 24 + 16 * DBIT && ((mon_t - 24) % 16) == 0) begin
               mon_f.data[(mon_t - 24) / 16] = o_tx;
            end else if (mon_t == 24 + 16 * DBIT) begin
               mon_f.stop_ok = (o_tx === 1'b1);
               got_q.push_back(mon_f);
               mon_on = 1'b0;
            end
         end
      end
      if (o_tx_done_tick === 1'b1) done_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [DBIT-1:0] d);
      @(posedge i_clk);
      #1;
      i_tx_start = 1'b1;
      i_din      = d;
      @(posedge i_clk);
      #1;
      i_tx_start = 1'b0;
      i_din      = DBIT'($urandom);
   endtask

   task automatic wait_frames(input int n, input int budget);
      for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge i_clk);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && o_busy !== 1'b0; i++) @(negedge i_clk);
   endtask

   task automatic test_reset();
      int bad;
      int d0;
      i_reset = 1'b1;
      tick_div = 1;
      repeat (5) @(negedge i_clk);
      n_checks++;
      if (o_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", o_tx); end
      n_checks++;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      n_checks++;
      if (o_tx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_tx_done_tick); end
      @(posedge i_clk);
      #3;
      i_reset = 1'b0;
      d0  = done_cnt;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done_tick !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL idle_after_reset: got %0d bad cycles expected 0", bad); end
      n_checks++;
      if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL idle_done: got %0d done ticks expected 0", done_cnt - d0); end
   endtask

   task automatic test_send_55();
      logic [DBIT-1:0] d;
      logic            exp_line;
      int              line_bad, done_bad, busy_bad, first_bad, d0;
      frame_t          f;
      logic [DBIT-1:0] e;
      d = 8'h55;
      tick_div = 1;
      d0 = done_cnt;
      line_bad = 0; done_bad = 0; busy_bad = 0; first_bad = -1;
      exp_q.push_back(d);
      send(d);
      for (int j = 0; j <= 170; j++) begin
         @(negedge i_clk);
         if (j >= 1 && j <= 16)        exp_line = 1'b0;
         else if (j >= 17 && j <= 144) exp_line = d[(j - 17) / 16];
         else                          exp_line = 1'b1;
         if (o_tx !== exp_line) begin line_bad++; if (first_bad < 0) first_bad = j; end
         if (o_tx_done_tick !== (j == 159)) done_bad++;
         if (o_busy !== (j <= 159)) busy_bad++;
      end
      n_checks++;
      if (line_bad !== 0) begin n_fail++; $display("FAIL line_55: got %0d wrong cycles (first at %0d) expected 0", line_bad, first_bad); end
      n_checks++;
      if (done_bad !== 0) begin n_fail++; $display("FAIL done_timing_55: got %0d wrong cycles expected 0", done_bad); end
      n_checks++;
      if (busy_bad !== 0) begin n_fail++; $display("FAIL busy_55: got %0d wrong cycles expected 0", busy_bad); end
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL done_count_55: got %0d expected 1", done_cnt - d0); end
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++; $display("FAIL frame_55: got no frame expected %h", d);
         void'(exp_q.pop_front());
      end else begin
         f = got_q.pop_front();
         e = exp_q.pop_front();
         if (f.data !== e || !f.start_ok || !f.stop_ok) begin
            n_fail++; $display("FAIL frame_55: got %h start %0d stop %0d expected %h start 1 stop 1", f.data, f.start_ok, f.stop_ok, e);
         end
      end
   endtask

   task automatic test_slow_a3();
      frame_t          f;
      logic [DBIT-1:0] e;
      int              d0;
      tick_div = 16;
      d0 = done_cnt;
      repeat (20) @(posedge i_clk);
      exp_q.push_back(8'hA3);
      send(8'hA3);
      wait_frames(1, 200 * 16);
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++; $display("FAIL frame_a3: got no frame expected a3");
         void'(exp_q.pop_front());
      end else begin
         f = got_q.pop_front();
         e = exp_q.pop_front();
         if (f.data !== e || !f.start_ok || !f.stop_ok) begin
            n_fail++; $display("FAIL frame_a3: got %h start %0d stop %0d expected %h start 1 stop 1", f.data, f.start_ok, f.stop_ok, e);
         end
      end
      wait_idle(40 * 16);
      n_checks++;
      if (o_busy !== 1'b0 || done_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL done_a3: got busy %b done %0d expected busy 0 done 1", o_busy, done_cnt - d0);
      end
   endtask

   task automatic test_tick_hold();
      frame_t f;
      logic   held;
      int     bad, d0;
      tick_div = 1;
      d0 = done_cnt;
      exp_q.push_back(8'h33);
      send(8'h33);
      repeat (40) @(negedge i_clk);
      tick_en = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      held = o_tx;
      bad  = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_clk);
         if (o_tx !== held || o_busy !== 1'b1 || o_tx_done_tick !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL tick_hold: got %0d changed cycles expected 0", bad); end
      tick_en = 1'b1;
      wait_frames(1, 400);
      wait_idle(100);
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++; $display("FAIL frame_hold: got no frame expected 33");
         void'(exp_q.pop_front());
      end else begin
         f = got_q.pop_front();
         if (f.data !== exp_q.pop_front() || !f.start_ok || !f.stop_ok) begin
            n_fail++; $display("FAIL frame_hold: got %h start %0d stop %0d expected 33", f.data, f.start_ok, f.stop_ok);
         end
      end
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL done_hold: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_ignore_restart();
      frame_t f;
      int     d0;
      tick_div = 1;
      d0 = done_cnt;
      exp_q.push_back(8'h0F);
      send(8'h0F);
      repeat (40) @(posedge i_clk);
      #1;
      i_tx_start = 1'b1;
      i_din      = 8'hFF;
      @(posedge i_clk);
      #1;
      i_tx_start = 1'b0;
      repeat (30) @(posedge i_clk);
      #1;
      i_din = 8'hC6;
      wait_frames(1, 400);
      wait_idle(100);
      repeat (40) @(negedge i_clk);
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++; $display("FAIL frame_0f: got no frame expected 0f");
         void'(exp_q.pop_front());
      end else begin
         f = got_q.pop_front();
         if (f.data !== exp_q.pop_front() || !f.start_ok || !f.stop_ok) begin
            n_fail++; $display("FAIL frame_0f: got %h start %0d stop %0d expected 0f", f.data, f.start_ok, f.stop_ok);
         end
      end
      n_checks++;
      if (done_cnt - d0 !== 1 || got_q.size() !== 0) begin
         n_fail++; $display("FAIL restart_ignored: got %0d done %0d extra frames expected 1 done 0 extra", done_cnt - d0, got_q.size());
      end
   endtask

   task automatic test_back_to_back();
      frame_t f1, f2;
      bit     seen;
      int     d0;
      tick_div = 1;
      d0   = done_cnt;
      seen = 1'b0;
      exp_q.push_back(8'h00);
      send(8'h00);
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge i_clk);
         if (o_tx_done_tick === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL done_wait_b2b: got no done tick within 400 cycles expected one"); end
      // strobe coincident with the done tick carries a decoy word
      i_tx_start = 1'b1;
      i_din      = 8'h3C;
      @(posedge i_clk);
      #1;
      n_checks++;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL coincident_start: got busy %b expected 0", o_busy); end
      i_din = 8'hFF;
      exp_q.push_back(8'hFF);
      @(posedge i_clk);
      #1;
      i_tx_start = 1'b0;
      n_checks++;
      if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b expected 1", o_busy); end
      wait_frames(2, 600);
      wait_idle(200);
      n_checks++;
      if (got_q.size() < 2) begin
         n_fail++; $display("FAIL frames_b2b: got %0d frames expected 2", got_q.size());
         exp_q.delete();
         got_q.delete();
      end else begin
         f1 = got_q.pop_front();
         f2 = got_q.pop_front();
         if (f1.data !== exp_q.pop_front() || f2.data !== exp_q.pop_front() ||
             !f1.start_ok || !f1.stop_ok || !f2.start_ok || !f2.stop_ok) begin
            n_fail++; $display("FAIL frames_b2b: got %h then %h expected 00 then ff", f1.data, f2.data);
         end
         n_checks++;
         if (f2.fall_cyc - f1.fall_cyc !== 161) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d cycles between start bits expected 161", f2.fall_cyc - f1.fall_cyc);
         end
      end
      n_checks++;
      if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL done_b2b: got %0d expected 2", done_cnt - d0); end
   endtask

   task automatic test_reset_mid_frame();
      frame_t f;
      int     d0;
      tick_div = 1;
      send(8'h52);
      d0 = done_cnt;
      repeat (69) @(posedge i_clk);
      #2;
      n_checks++;
      if (o_tx !== 1'b0) begin n_fail++; $display("FAIL bit3_before_reset: got %b expected 0", o_tx); end
      #1;
      i_reset = 1'b1;
      #1;
      n_checks++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done_tick !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: got tx %b busy %b done %b expected 1 0 0", o_tx, o_busy, o_tx_done_tick);
      end
      repeat (3) @(negedge i_clk);
      @(posedge i_clk);
      #3;
      i_reset = 1'b0;
      repeat (200) @(negedge i_clk);
      n_checks++;
      if (done_cnt - d0 !== 0 || got_q.size() !== 0 || o_tx !== 1'b1) begin
         n_fail++; $display("FAIL aborted_frame: got done %0d frames %0d tx %b expected 0 0 1", done_cnt - d0, got_q.size(), o_tx);
      end
      exp_q.push_back(8'h81);
      send(8'h81);
      wait_frames(1, 400);
      wait_idle(100);
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++; $display("FAIL frame_81: got no frame expected 81");
         void'(exp_q.pop_front());
      end else begin
         f = got_q.pop_front();
         if (f.data !== exp_q.pop_front() || !f.start_ok || !f.stop_ok) begin
            n_fail++; $display("FAIL frame_81: got %h start %0d stop %0d expected 81", f.data, f.start_ok, f.stop_ok);
         end
      end
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL done_81: got %0d expected 1", done_cnt - d0); end
   endtask

   initial begin
      i_reset    = 1'b1;
      i_tx_start = 1'b0;
      i_din      = '0;
      test_reset();
      test_send_55();
      test_slow_a3();
      test_tick_hold();
      test_ignore_restart();
      test_back_to_back();
      test_reset_mid_frame();
      n_checks++;
      if (exp_q.size() !== 0 || got_q.size() !== 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d expected %0d decoded left expected 0 0", exp_q.size(), got_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
